// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared widths, state encodings and constants for the I-cache refill path
package icache_refill_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int MEM_W  = 8;
    localparam logic RstEnable = 1'b1;
    localparam logic True_v    = 1'b1;
    localparam logic False_v   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        WRITE = 2'b10
    } state_t;
endpackage

// File: rtl/icache_refill.sv
// icache_refill: forwards I-cache hits to IF and refills misses from byte-wide memory
import icache_refill_pkg::*;
module icache_refill (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              cache_hit_i,
    input  logic [INST_W-1:0] cache_inst_i,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_waddr_o,
    output logic [INST_W-1:0] cache_winst_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_grant_i,
    input  logic [MEM_W-1:0]  mem_din_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic              busy_o
);
    state_t                  state;
    logic [ADDR_W-1:0]       line_addr;
    logic [2:0]              a_cnt;
    logic [1:0]              d_cnt;
    logic                    pending;
    logic [3:0][MEM_W-1:0]   byte_q;
    logic                    hit_v;
    logic [INST_W-1:0]       hit_inst;
    logic                    hit_now;
    logic                    grant_ok;

    assign hit_now  = state == IDLE && if_req_i && cache_hit_i && !flush_i;
    assign grant_ok = mem_req_o && mem_grant_i;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= IDLE;
            line_addr <= ZeroWord;
            a_cnt     <= '0;
            d_cnt     <= '0;
            pending   <= False_v;
            byte_q    <= '0;
            hit_v     <= False_v;
            hit_inst  <= ZeroWord;
        end else if (rdy) begin
            hit_v <= hit_now;
            if (hit_now)
                hit_inst <= cache_inst_i;
            // WRITE always commits: the assembled word already matches line_addr
            if (flush_i && state != WRITE) begin
                state   <= IDLE;
                pending <= False_v;
            end else begin
                case (state)
                    IDLE: if (if_req_i && !cache_hit_i) begin
                        line_addr <= if_addr_i & ~32'h3;
                        a_cnt     <= '0;
                        d_cnt     <= '0;
                        pending   <= False_v;
                        state     <= FETCH;
                    end
                    FETCH: begin
                        pending <= grant_ok;
                        if (grant_ok)
                            a_cnt <= a_cnt + 3'd1;
                        if (pending == True_v) begin
                            byte_q[d_cnt] <= mem_din_i;
                            d_cnt         <= d_cnt + 2'd1;
                            if (d_cnt == 2'd3)
                                state <= WRITE;
                        end
                    end
                    WRITE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o        = state != IDLE;
    assign mem_req_o     = state == FETCH && !a_cnt[2];
    assign mem_addr_o    = mem_req_o ? line_addr + {{(ADDR_W-3){1'b0}}, a_cnt} : ZeroWord;
    assign cache_we_o    = state == WRITE;
    assign cache_waddr_o = cache_we_o ? line_addr : ZeroWord;
    assign cache_winst_o = cache_we_o ? byte_q : ZeroWord;
    assign inst_valid_o  = hit_v || (cache_we_o && !flush_i);
    assign inst_o        = cache_we_o ? byte_q : hit_inst;
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed stimulus with queued expectations checked by an output monitor
module tb_icache_refill;
    logic        clk = 0, rst = 1, rdy = 1, flush_i = 0, if_req_i = 0, cache_hit_i = 0;
    logic [31:0] if_addr_i = 0, cache_inst_i = 0;
    logic        cache_we_o, mem_req_o, mem_grant_i = 1, inst_valid_o, busy_o;
    logic [31:0] cache_waddr_o, cache_winst_o, mem_addr_o, inst_o;
    logic [7:0]  mem_din_i = 0;
    logic [7:0]  mem [0:255];

    typedef struct { logic [31:0] a; logic [31:0] d; int c; } exp_t;
    exp_t        iq[$], wq[$];
    logic [31:0] aq[$];
    int          cyc = 0, n_cmp = 0, n_err = 0;

    icache_refill dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .if_req_i(if_req_i),
        .if_addr_i(if_addr_i), .cache_hit_i(cache_hit_i), .cache_inst_i(cache_inst_i),
        .cache_we_o(cache_we_o), .cache_waddr_o(cache_waddr_o), .cache_winst_o(cache_winst_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_grant_i(mem_grant_i),
        .mem_din_i(mem_din_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_req_o && mem_grant_i && rdy) mem_din_i <= mem[mem_addr_o[7:0]];

    always @(negedge clk) if (!rst) begin
        if (mem_req_o && mem_grant_i && rdy) begin
            n_cmp++;
            if (aq.size() == 0) begin
                n_err++;
                $display("FAIL mem_addr: unexpected grant of %h at cycle %0d", mem_addr_o, cyc);
            end else begin
                logic [31:0] ea;
                ea = aq.pop_front();
                if (mem_addr_o !== ea) begin
                    n_err++;
                    $display("FAIL mem_addr: got %h want %h", mem_addr_o, ea);
                end
            end
        end
        if (inst_valid_o) begin
            n_cmp++;
            if (iq.size() == 0) begin
                n_err++;
                $display("FAIL inst: unexpected inst_valid_o with %h at cycle %0d", inst_o, cyc);
            end else begin
                exp_t e;
                e = iq.pop_front();
                if (inst_o !== e.d || cyc != e.c) begin
                    n_err++;
                    $display("FAIL inst: got %h at cycle %0d want %h at cycle %0d", inst_o, cyc, e.d, e.c);
                end
            end
        end
        if (cache_we_o) begin
            n_cmp++;
            if (wq.size() == 0) begin
                n_err++;
                $display("FAIL cache_write: unexpected write %h<=%h at cycle %0d", cache_waddr_o, cache_winst_o, cyc);
            end else begin
                exp_t e;
                e = wq.pop_front();
                if (cache_waddr_o !== e.a || cache_winst_o !== e.d || cyc != e.c) begin
                    n_err++;
                    $display("FAIL cache_write: got %h<=%h at cycle %0d want %h<=%h at cycle %0d",
                             cache_waddr_o, cache_winst_o, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    task automatic start_miss(input logic [31:0] a, input int n_adr, output int t);
        t = cyc;
        if_req_i = 1;
        if_addr_i = a;
        cache_hit_i = 0;
        for (int i = 0; i < n_adr; i++) aq.push_back((a & ~32'h3) + i);
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] d, input int c);
        iq.push_back('{a, d, c});
        wq.push_back('{a, d, c});
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h13; mem[8'h11] = 8'h05; mem[8'h12] = 8'h10; mem[8'h13] = 8'h00;
        mem[8'h20] = 8'h93; mem[8'h21] = 8'h00; mem[8'h22] = 8'h20; mem[8'h23] = 8'h00;
        mem[8'h30] = 8'hEF; mem[8'h31] = 8'hBE; mem[8'h32] = 8'hAD; mem[8'h33] = 8'hDE;
        tick(); tick();
        chk("rst_inst_valid", {31'b0, inst_valid_o}, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_cache_we", {31'b0, cache_we_o}, 0);
        chk("rst_waddr", cache_waddr_o, 0);
        chk("rst_winst", cache_winst_o, 0);
        chk("rst_mem_req", {31'b0, mem_req_o}, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        rst = 0;
        tick();
        // hit: delivered next cycle, no memory traffic
        if_req_i = 1; if_addr_i = 32'h0000_1004; cache_hit_i = 1; cache_inst_i = 32'h00A0_0093;
        iq.push_back('{32'h1004, 32'h00A0_0093, cyc + 1});
        tick();
        if_req_i = 0; cache_hit_i = 0;
        tick(); tick();
        // miss with grant tied high
        start_miss(32'h10, 4, t);
        expect_word(32'h10, 32'h0010_0513, t + 6);
        run_to(t + 6);
        if_req_i = 0;
        run_to(t + 8);
        // grant withheld for two cycles after byte 0
        start_miss(32'h10, 4, t);
        expect_word(32'h10, 32'h0010_0513, t + 8);
        run_to(t + 2);
        mem_grant_i = 0;
        chk("stall_addr0", mem_addr_o, 32'h11);
        tick();
        chk("stall_addr1", mem_addr_o, 32'h11);
        tick();
        mem_grant_i = 1;
        run_to(t + 8);
        if_req_i = 0;
        run_to(t + 10);
        // flush in the cycle byte 2 is captured
        start_miss(32'h30, 4, t);
        run_to(t + 4);
        flush_i = 1; if_req_i = 0;
        tick();
        flush_i = 0;
        chk("flush_busy", {31'b0, busy_o}, 0);
        chk("flush_mem_req", {31'b0, mem_req_o}, 0);
        run_to(t + 9);
        start_miss(32'h20, 4, t);
        expect_word(32'h20, 32'h0020_0093, t + 6);
        run_to(t + 6);
        if_req_i = 0;
        run_to(t + 8);
        // reset mid-refill abandons without a cache write
        start_miss(32'h20, 2, t);
        run_to(t + 3);
        rst = 1; if_req_i = 0;
        tick();
        chk("midrst_busy", {31'b0, busy_o}, 0);
        chk("midrst_mem_req", {31'b0, mem_req_o}, 0);
        rst = 0;
        tick(); tick();
        // rdy low for three cycles mid-fetch; low address bits are ignored
        start_miss(32'h12, 4, t);
        expect_word(32'h10, 32'h0010_0513, t + 9);
        run_to(t + 2);
        rdy = 0;
        chk("frz_addr0", mem_addr_o, 32'h11);
        tick();
        chk("frz_addr1", mem_addr_o, 32'h11);
        tick();
        chk("frz_addr2", mem_addr_o, 32'h11);
        chk("frz_busy", {31'b0, busy_o}, 1);
        tick();
        rdy = 1;
        run_to(t + 9);
        if_req_i = 0;
        run_to(t + 12);
        chk("inst_left", iq.size(), 0);
        chk("write_left", wq.size(), 0);
        chk("addr_left", aq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
